// File: rtl/usart_rx_pkg.sv
// Shared types and helpers for the USART receive control block.
package usart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_t;

  localparam logic [1:0] UPM_NONE = 2'b00;
  localparam logic [1:0] UPM_EVEN = 2'b10;
  localparam logic [1:0] UPM_ODD  = 2'b11;

  // Character size code to number of data bits; unknown codes fall back to 8.
  function automatic logic [3:0] chsz_to_bits(input logic [2:0] chsz);
    logic [3:0] bits;
    case (chsz)
      3'd0:    bits = 4'd5;
      3'd1:    bits = 4'd6;
      3'd2:    bits = 4'd7;
      3'd7:    bits = 4'd9;
      default: bits = 4'd8;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/usart_rx_sampler.sv
// Oversampling sample counter, falling-edge detector and 3-sample majority vote.
module usart_rx_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic clear,
  input  logic run,
  output logic fall,
  output logic vote_point,
  output logic bit_value
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] SAMP0    = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SAMP1    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] VOTE_CNT = CW'(OVERSAMPLE / 2 + 1);

  logic [CW-1:0] cnt;
  logic          prev_rx;
  logic          samp0;
  logic          samp1;

  // Track the previous line level, run the per-bit counter and capture the first two vote samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      prev_rx <= 1'b1;
      samp0   <= 1'b0;
      samp1   <= 1'b0;
    end else begin
      prev_rx <= rx;
      if (clear)
        cnt <= '0;
      else if (run)
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      else
        cnt <= '0;
      if (run && cnt == SAMP0)
        samp0 <= rx;
      if (run && cnt == SAMP1)
        samp1 <= rx;
    end
  end

  // The third sample is the live input at the vote point, so the vote resolves in that cycle.
  always_comb begin
    fall       = prev_rx & ~rx;
    vote_point = run & (cnt == VOTE_CNT);
    bit_value  = (samp0 & samp1) | (samp0 & rx) | (samp1 & rx);
  end

endmodule

// File: rtl/usart_rx_ctrl.sv
// USART receive control: frame FSM, bit counter, shift register and held status flags.
module usart_rx_ctrl
  import usart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_MAX   = 9
) (
  input  logic                i_rxclk,
  input  logic                i_rst_n,
  input  logic                i_rx,
  input  logic                i_rx_en,
  input  logic [2:0]          i_chsz,
  input  logic [1:0]          i_upm,
  input  logic                i_usbs,
  input  logic                i_data_read,
  output logic [DATA_MAX-1:0] o_data,
  output logic                o_rx_valid,
  output logic                o_receive_complete,
  output logic                o_frame_error,
  output logic                o_parity_error,
  output logic                o_data_overrun,
  output logic                o_busy
);

  rx_state_t           state;
  rx_state_t           next_state;
  logic                fall;
  logic                vote;
  logic                bit_val;
  logic                start_ok;
  logic                finish;
  logic                accept;
  logic                exp_par;
  logic                fe_now;
  logic [3:0]          nbits;
  logic [1:0]          upm_lat;
  logic                usbs_lat;
  logic [3:0]          bit_cnt;
  logic [DATA_MAX-1:0] shift_reg;
  logic                fe_acc;
  logic                pe_acc;

  usart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk        (i_rxclk),
    .rst_n      (i_rst_n),
    .rx         (i_rx),
    .clear      (start_ok),
    .run        (state != IDLE),
    .fall       (fall),
    .vote_point (vote),
    .bit_value  (bit_val)
  );

  // State register.
  always_ff @(posedge i_rxclk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state decode; a finished frame drops straight back to IDLE in its stop-bit vote cycle.
  always_comb begin
    next_state = state;
    finish     = 1'b0;
    if (!i_rx_en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:   if (fall) next_state = START;
        START:  if (vote) next_state = bit_val ? IDLE : DATA;
        DATA:   if (vote && bit_cnt == nbits - 4'd1)
                  next_state = upm_lat[1] ? PARITY : STOP1;
        PARITY: if (vote) next_state = STOP1;
        STOP1:  if (vote) begin
                  if (usbs_lat) begin
                    next_state = STOP2;
                  end else begin
                    next_state = IDLE;
                    finish     = 1'b1;
                  end
                end
        STOP2:  if (vote) begin
                  next_state = IDLE;
                  finish     = 1'b1;
                end
        default: next_state = IDLE;
      endcase
    end
  end

  // Frame-level helper terms, including the stop bit being voted in the finishing cycle.
  always_comb begin
    start_ok = (state == IDLE) & i_rx_en & fall;
    exp_par  = (^shift_reg) ^ (upm_lat == UPM_ODD);
    fe_now   = fe_acc | (vote & ((state == STOP1) | (state == STOP2)) & ~bit_val);
    accept   = finish & (~o_rx_valid | i_data_read);
  end

  // Latch the frame format on the start edge and assemble data and error state per voted bit.
  always_ff @(posedge i_rxclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      nbits     <= 4'd0;
      upm_lat   <= UPM_NONE;
      usbs_lat  <= 1'b0;
      bit_cnt   <= 4'd0;
      shift_reg <= '0;
      fe_acc    <= 1'b0;
      pe_acc    <= 1'b0;
    end else if (start_ok) begin
      nbits     <= chsz_to_bits(i_chsz);
      upm_lat   <= (i_upm == UPM_EVEN || i_upm == UPM_ODD) ? i_upm : UPM_NONE;
      usbs_lat  <= i_usbs;
      bit_cnt   <= 4'd0;
      shift_reg <= '0;
      fe_acc    <= 1'b0;
      pe_acc    <= 1'b0;
    end else if (vote && i_rx_en) begin
      case (state)
        DATA: begin
          for (int i = 0; i < DATA_MAX; i++)
            if (bit_cnt == 4'(i))
              shift_reg[i] <= bit_val;
          bit_cnt <= bit_cnt + 4'd1;
        end
        PARITY:       pe_acc <= (bit_val != exp_par);
        STOP1, STOP2: if (!bit_val) fe_acc <= 1'b1;
        default: ;
      endcase
    end
  end

  // Hand a finished frame to software, or flag overrun if the previous word is still unread.
  always_ff @(posedge i_rxclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data             <= '0;
      o_rx_valid         <= 1'b0;
      o_receive_complete <= 1'b0;
      o_frame_error      <= 1'b0;
      o_parity_error     <= 1'b0;
      o_data_overrun     <= 1'b0;
    end else begin
      o_receive_complete <= 1'b0;
      if (accept) begin
        o_data             <= shift_reg;
        o_rx_valid         <= 1'b1;
        o_frame_error      <= fe_now;
        o_parity_error     <= pe_acc;
        o_receive_complete <= 1'b1;
        if (i_data_read)
          o_data_overrun <= 1'b0;
      end else if (finish) begin
        o_data_overrun <= 1'b1;
      end else if (i_data_read) begin
        o_rx_valid     <= 1'b0;
        o_frame_error  <= 1'b0;
        o_parity_error <= 1'b0;
        o_data_overrun <= 1'b0;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_usart_rx_ctrl.sv
// Directed self-checking bench for usart_rx_ctrl at OVERSAMPLE=16, DATA_MAX=9.
module tb_usart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_en = 1'b1;
  logic [2:0] chsz = 3'd3;
  logic [1:0] upm = 2'b00;
  logic       usbs = 1'b0;
  logic       data_read = 1'b0;
  logic [8:0] o_data;
  logic       o_rx_valid, o_receive_complete, o_frame_error;
  logic       o_parity_error, o_data_overrun, o_busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;

  usart_rx_ctrl #(.OVERSAMPLE(16), .DATA_MAX(9)) dut (
    .i_rxclk            (clk),
    .i_rst_n            (rst_n),
    .i_rx               (rx),
    .i_rx_en            (rx_en),
    .i_chsz             (chsz),
    .i_upm              (upm),
    .i_usbs             (usbs),
    .i_data_read        (data_read),
    .o_data             (o_data),
    .o_rx_valid         (o_rx_valid),
    .o_receive_complete (o_receive_complete),
    .o_frame_error      (o_frame_error),
    .o_parity_error     (o_parity_error),
    .o_data_overrun     (o_data_overrun),
    .o_busy             (o_busy)
  );

  always #5 clk = ~clk;

  // Count rising edges so pulse latency can be measured from the start edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every receive-complete pulse seen between clock edges.
  always @(negedge clk) begin
    if (o_receive_complete === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [2:0] c, input logic [1:0] p, input logic s);
    @(negedge clk);
    chsz = c;
    upm  = p;
    usbs = s;
  endtask

  task automatic send_frame(input logic [8:0] word, input int nbits, input logic has_par,
                            input logic par_bit, input logic stop_val, input int nstop);
    @(negedge clk);
    rx = 1'b0;
    edge_cyc = cyc + 1;
    repeat (16) @(negedge clk);
    for (int i = 0; i < nbits; i++) drive_bit(word[i], 16);
    if (has_par) drive_bit(par_bit, 16);
    for (int s = 0; s < nstop; s++) drive_bit(stop_val, 16);
    rx = 1'b1;
  endtask

  task automatic do_read();
    @(negedge clk);
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (o_data !== 9'h000) begin n_err++; $display("[TB] FAIL reset_data: got %h expected 000", o_data); end
    n_vec++; if (o_rx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b expected 0", o_rx_valid); end
    n_vec++; if (o_receive_complete !== 1'b0) begin n_err++; $display("[TB] FAIL reset_complete: got %b expected 0", o_receive_complete); end
    n_vec++; if ({o_frame_error, o_parity_error, o_data_overrun} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_flags: got %b expected 000", {o_frame_error, o_parity_error, o_data_overrun}); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    int p0;
    set_cfg(3'd3, 2'b00, 1'b0);
    p0 = pulse_cnt;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1);
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("[TB] FAIL 8n1_pulses: got %0d expected 1", pulse_cnt - p0); end
    n_vec++; if (last_pulse_cyc - edge_cyc !== 154) begin n_err++; $display("[TB] FAIL 8n1_latency: got %0d expected 154", last_pulse_cyc - edge_cyc); end
    n_vec++; if (o_data !== 9'h0A5) begin n_err++; $display("[TB] FAIL 8n1_data: got %h expected 0a5", o_data); end
    n_vec++; if (o_rx_valid !== 1'b1) begin n_err++; $display("[TB] FAIL 8n1_valid: got %b expected 1", o_rx_valid); end
    n_vec++; if ({o_frame_error, o_parity_error, o_data_overrun} !== 3'b000) begin n_err++; $display("[TB] FAIL 8n1_flags: got %b expected 000", {o_frame_error, o_parity_error, o_data_overrun}); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL 8n1_busy: got %b expected 0", o_busy); end
    do_read();
    n_vec++; if (o_rx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL 8n1_read_valid: got %b expected 0", o_rx_valid); end
  endtask

  task automatic test_9e2_parity();
    set_cfg(3'd7, 2'b10, 1'b1);
    send_frame(9'h1C3, 9, 1'b1, 1'b1, 1'b1, 2);
    n_vec++; if (o_data !== 9'h1C3) begin n_err++; $display("[TB] FAIL 9e2_data: got %h expected 1c3", o_data); end
    n_vec++; if ({o_frame_error, o_parity_error} !== 2'b00) begin n_err++; $display("[TB] FAIL 9e2_errors: got %b expected 00", {o_frame_error, o_parity_error}); end
    n_vec++; if (o_rx_valid !== 1'b1) begin n_err++; $display("[TB] FAIL 9e2_valid: got %b expected 1", o_rx_valid); end
    do_read();
    send_frame(9'h1C3, 9, 1'b1, 1'b0, 1'b1, 2);
    n_vec++; if (o_data !== 9'h1C3) begin n_err++; $display("[TB] FAIL 9e2_bad_data: got %h expected 1c3", o_data); end
    n_vec++; if (o_parity_error !== 1'b1) begin n_err++; $display("[TB] FAIL 9e2_bad_perr: got %b expected 1", o_parity_error); end
    n_vec++; if (o_frame_error !== 1'b0) begin n_err++; $display("[TB] FAIL 9e2_bad_ferr: got %b expected 0", o_frame_error); end
    do_read();
    n_vec++; if (o_parity_error !== 1'b0) begin n_err++; $display("[TB] FAIL 9e2_read_perr: got %b expected 0", o_parity_error); end
  endtask

  task automatic test_7o1_frame_error();
    int p0;
    set_cfg(3'd2, 2'b11, 1'b0);
    p0 = pulse_cnt;
    send_frame(9'h035, 7, 1'b1, 1'b1, 1'b0, 1);
    n_vec++; if (o_frame_error !== 1'b1) begin n_err++; $display("[TB] FAIL 7o1_ferr: got %b expected 1", o_frame_error); end
    n_vec++; if (o_parity_error !== 1'b0) begin n_err++; $display("[TB] FAIL 7o1_perr: got %b expected 0", o_parity_error); end
    n_vec++; if (o_rx_valid !== 1'b1) begin n_err++; $display("[TB] FAIL 7o1_valid: got %b expected 1", o_rx_valid); end
    n_vec++; if (o_data !== 9'h035) begin n_err++; $display("[TB] FAIL 7o1_data: got %h expected 035", o_data); end
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("[TB] FAIL 7o1_pulses: got %0d expected 1", pulse_cnt - p0); end
    do_read();
    n_vec++; if (o_frame_error !== 1'b0) begin n_err++; $display("[TB] FAIL 7o1_read_ferr: got %b expected 0", o_frame_error); end
  endtask

  task automatic test_false_start();
    int p0;
    int busy_cnt;
    set_cfg(3'd3, 2'b00, 1'b0);
    p0 = pulse_cnt;
    busy_cnt = 0;
    @(negedge clk);
    rx = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_busy === 1'b1) busy_cnt++;
      if (k == 3) rx = 1'b1;
    end
    n_vec++; if (busy_cnt !== 10) begin n_err++; $display("[TB] FAIL glitch_busy_cycles: got %0d expected 10", busy_cnt); end
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", pulse_cnt - p0); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL glitch_idle: got %b expected 0", o_busy); end
    n_vec++; if (o_rx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL glitch_valid: got %b expected 0", o_rx_valid); end
  endtask

  task automatic test_back_to_back();
    int p0;
    set_cfg(3'd3, 2'b00, 1'b0);
    p0 = pulse_cnt;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, 1);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, 1);
    n_vec++; if (o_data !== 9'h011) begin n_err++; $display("[TB] FAIL ovr_data: got %h expected 011", o_data); end
    n_vec++; if (o_data_overrun !== 1'b1) begin n_err++; $display("[TB] FAIL ovr_flag: got %b expected 1", o_data_overrun); end
    n_vec++; if (o_rx_valid !== 1'b1) begin n_err++; $display("[TB] FAIL ovr_valid: got %b expected 1", o_rx_valid); end
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("[TB] FAIL ovr_pulses: got %0d expected 1", pulse_cnt - p0); end
    do_read();
    n_vec++; if ({o_rx_valid, o_frame_error, o_parity_error, o_data_overrun} !== 4'b0000) begin n_err++; $display("[TB] FAIL ovr_read_flags: got %b expected 0000", {o_rx_valid, o_frame_error, o_parity_error, o_data_overrun}); end
  endtask

  task automatic test_disable();
    int p0;
    logic [7:0] w;
    w = 8'h5A;
    set_cfg(3'd3, 2'b00, 1'b0);
    p0 = pulse_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_bit(w[i], 16);
    drive_bit(w[3], 8);
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("[TB] FAIL dis_busy_before: got %b expected 1", o_busy); end
    rx_en = 1'b0;
    @(negedge clk);
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL dis_idle: got %b expected 0", o_busy); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rx_en = 1'b1;
    repeat (40) @(negedge clk);
    n_vec++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("[TB] FAIL dis_pulses: got %0d expected 0", pulse_cnt - p0); end
    n_vec++; if (o_rx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL dis_valid: got %b expected 0", o_rx_valid); end
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1);
    n_vec++; if (o_data !== 9'h05A) begin n_err++; $display("[TB] FAIL dis_next_data: got %h expected 05a", o_data); end
    n_vec++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("[TB] FAIL dis_next_pulses: got %0d expected 1", pulse_cnt - p0); end
    do_read();
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_busy_before: got %b expected 1", o_busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_busy_after: got %b expected 0", o_busy); end
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_9e2_parity();
    test_7o1_frame_error();
    test_false_start();
    test_back_to_back();
    test_disable();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
